mimc_cipher_arbiter: RTL and testbench
======================================

# mimc_cipher_arbiter

Round-robin arbiter and sequencer that shares one `mimc_cipher` core (exponent 7, 91 rounds) among `NUM_REQ` requesters. It accepts (plaintext, key) jobs over per-requester valid/ready handshakes and issues them to the core one at a time. It returns each ciphertext, tagged with the requester index, on a single response channel. The block sits between hash front-ends (sponge / Miyaguchi-Preneel controllers) and the shared cipher datapath.

## Interface
- `N_BITS`, 254, field element width
- `NUM_REQ`, 4, number of requesters (2..16)
- `ID_W`, `$clog2(NUM_REQ)`, requester index width
- `TIMEOUT`, 1023, max cycles waiting for `core_done`; used only with `MIMC_ARB_TIMEOUT_EN`

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester job valid
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high
- `req_in`  in  NUM_REQ*N_BITS  packed plaintexts; requester i at `[i*N_BITS +: N_BITS]`
- `req_key`  in  NUM_REQ*N_BITS  packed keys, same packing
- `resp_valid`  out  1  response valid
- `resp_ready`  in  1  response accept
- `resp_out`  out  N_BITS  ciphertext
- `resp_id`  out  ID_W  index of the requester that owns the response
- `resp_err`  out  1  job timed out; `resp_out` = 0
- `busy`  out  1  high in any state other than IDLE
- `core_en`  out  1  single-cycle start pulse to the core
- `core_in`, `core_key`  out  N_BITS each  operands to the core, held stable from issue until done
- `core_out`  in  N_BITS  core result
- `core_done`  in  1  core result-valid pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any `req_valid` is high, grant g = first asserted index searching from `ptr+1` modulo NUM_REQ.
  - `req_ready[g]` = 1, combinational in the same cycle.
  - On the handshake, latch `req_in[g]`, `req_key[g]` and g. Set `ptr` = g and go to ISSUE.
- ISSUE: `core_en` = 1 for exactly one cycle; go to WAIT.
- WAIT
  - On `core_done`: register `core_out` into `resp_out`, set `resp_err` = 0, go to RESP.
  - `core_done` seen in any other state is ignored.
- RESP: `resp_valid` = 1 and `resp_out`/`resp_id`/`resp_err` held stable until `resp_valid & resp_ready`; then go to IDLE.
- Only one job is in flight at a time. No new grant is made until the response is accepted.
- Requesters must hold `req_valid` and operands until `req_ready`. A requester that drops `req_valid` before the grant loses nothing.
- `ptr` advances only on an accepted grant. A single persistent requester is re-granted every job.

## Timing
- Reset values:
  - all outputs = 0
  - state = IDLE
  - `ptr` = NUM_REQ-1, so requester 0 wins first
  - operand, ID and result registers = 0
- Latency, with the request handshake in cycle T and core latency L (`core_done` at T+1+L):
  - `core_en` high in cycle T+1
  - `resp_valid` high from cycle T+2+L
  - earliest next grant in the cycle after the response handshake
- Throughput: one job per L+3 cycles with `resp_ready` held high.
- If `resp_ready` is already high when `resp_valid` rises, the response completes in that cycle.
- Reset mid-operation: all state clears immediately. The in-flight job is dropped with no response. The core must be reset by the same `rst`.

## Configuration
- `MIMC_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - If `core_done` has not arrived after TIMEOUT cycles, go to RESP with `resp_err` = 1 and `resp_out` = 0.
  - A late `core_done` after the timeout is ignored.
- Undefined: no counter is built, `resp_err` is tied to 0, and WAIT lasts indefinitely.

## Test plan
Bench core model: `done` pulses 10 cycles after `en`; `out` = `in` + `key`.
- Single job: req 2, in=5, key=7 → `core_en` at T+1; `resp_valid` at T+12 with `resp_out`=12, `resp_id`=2, `resp_err`=0.
- Simultaneous valid on reqs 1 and 3 after reset → grant order 1, then 3; `resp_id` sequence 1, 3.
- All four valid continuously → `resp_id` sequence 0,1,2,3,0; `req_ready` is one-hot or zero in every cycle.
- `resp_ready` held low 20 cycles → `resp_valid`, `resp_out` and `resp_id` stable; `req_ready` stays 0 for all requesters; next grant in the cycle after `resp_ready` is raised.
- `rst` asserted in WAIT → all outputs 0 immediately; after release, a new req 0 job (in=1, key=1) returns `resp_out`=2.
- With `MIMC_ARB_TIMEOUT_EN` and a core that never sends `done` → `resp_err`=1 and `resp_out`=0 after TIMEOUT cycles in WAIT; a later stray `core_done` produces no response.

Source files
------------

// File: rtl/mimc_cipher_arbiter.sv
// Round-robin arbiter/sequencer sharing one MiMC cipher core among NUM_REQ requesters.
// Optional WAIT-state watchdog is built when MIMC_ARB_TIMEOUT_EN is defined.
module mimc_cipher_arbiter #(
  parameter int N_BITS  = 254,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*N_BITS-1:0] req_in,
  input  logic [NUM_REQ*N_BITS-1:0] req_key,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [N_BITS-1:0]         resp_out,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      core_en,
  output logic [N_BITS-1:0]         core_in,
  output logic [N_BITS-1:0]         core_key,
  input  logic [N_BITS-1:0]         core_out,
  input  logic                      core_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                           state, state_nxt;
  logic [ID_W-1:0]                  ptr, gnt, gnt_hi, gnt_lo;
  logic                             hi_vld, lo_vld, gnt_vld, grant, timeout_hit;
  logic [NUM_REQ-1:0][N_BITS-1:0]   in_arr, key_arr;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_cfg_check
    $error("mimc_cipher_arbiter: unsupported NUM_REQ or TIMEOUT");
  end

  assign in_arr  = req_in;
  assign key_arr = req_key;

  // Two passes: lowest valid index above ptr wins, else lowest at/below ptr.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    gnt_hi = '0;
    gnt_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && ID_W'(i) > ptr) begin
        hi_vld = 1'b1;
        gnt_hi = ID_W'(i);
      end
      if (req_valid[i] && ID_W'(i) <= ptr) begin
        lo_vld = 1'b1;
        gnt_lo = ID_W'(i);
      end
    end
    gnt_vld = hi_vld | lo_vld;
    gnt     = hi_vld ? gnt_hi : gnt_lo;
  end

  assign grant = (state == IDLE) && gnt_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    core_en    = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt] = 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        core_en   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (core_done || timeout_hit) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay registered until the next grant, so the core sees them stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= ID_W'(NUM_REQ - 1);
      resp_id  <= '0;
      core_in  <= '0;
      core_key <= '0;
      resp_out <= '0;
    end else begin
      if (grant) begin
        ptr      <= gnt;
        resp_id  <= gnt;
        core_in  <= in_arr[gnt];
        core_key <= key_arr[gnt];
      end
      if (state == WAIT && core_done) resp_out <= core_out;
      else if (timeout_hit)           resp_out <= '0;
    end
  end

`ifdef MIMC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               wait_cnt <= '0;
    else if (state != WAIT) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 1'b1;
  end

  // A done arriving in the final WAIT cycle still wins over the timeout.
  assign timeout_hit = (state == WAIT) && !core_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            resp_err <= 1'b0;
    else if (state == WAIT && core_done) resp_err <= 1'b0;
    else if (timeout_hit)                resp_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mimc_cipher_arbiter.sv
// Directed bench for mimc_cipher_arbiter with an add-based stand-in core (done 10 cycles after en).
module tb_mimc_cipher_arbiter;
  localparam int N   = 254;
  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int TO  = 30;
  localparam int LAT = 10;

  typedef logic [N-1:0] fe_t;
  typedef struct { fe_t in; fe_t key; } job_t;
  typedef struct { int r; fe_t in; fe_t key; fe_t exp_out; } vec_t;
  typedef struct { int id; fe_t out; logic err; int cyc; } resp_t;
  typedef struct { int id; int cyc; } gnt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]        req_valid, req_ready;
  logic [NR-1:0][N-1:0] req_in, req_key;
  logic                 resp_valid, resp_ready, resp_err, busy, core_en, core_done;
  fe_t                  resp_out, core_in, core_key, core_out;
  logic [IW-1:0]        resp_id;

  always #5 clk = ~clk;

  mimc_cipher_arbiter #(.N_BITS(N), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in(req_in), .req_key(req_key), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_id(resp_id), .resp_err(resp_err), .busy(busy),
    .core_en(core_en), .core_in(core_in), .core_key(core_key),
    .core_out(core_out), .core_done(core_done)
  );

  // Stand-in core: result is in+key, done pulses LAT cycles after en.
  int ccnt;
  bit no_done = 1'b0;
  bit stray_done = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst)             ccnt <= 0;
    else if (core_en)     ccnt <= LAT;
    else if (ccnt != 0)   ccnt <= ccnt - 1;
  end
  assign core_done = (ccnt == 1 && !no_done) || stray_done;
  assign core_out  = core_in + core_key;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  job_t  jobs [NR][16];
  int    head [NR];
  int    tail [NR];
  resp_t rl[$];
  gnt_t  gl[$];
  int    el[$];
  vec_t  vec [4];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (head[i] < tail[i]);
      req_in[i]    = (head[i] < tail[i]) ? jobs[i][head[i]].in  : '0;
      req_key[i]   = (head[i] < tail[i]) ? jobs[i][head[i]].key : '0;
    end
  endtask

  // Sample/log mid-cycle, then drive the next cycle's inputs just after the edge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      chk("ready_onehot", 256'(req_ready & (req_ready - 4'd1)), 256'd0);
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) begin
          gl.push_back('{i, cyc});
          head[i]++;
        end
      if (core_en) el.push_back(cyc);
      if (resp_valid && resp_ready) rl.push_back('{int'(resp_id), resp_out, resp_err, cyc});
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push(input int r, input fe_t in, input fe_t key);
    jobs[r][tail[r]] = '{in, key};
    tail[r]++;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int c = 0;
    while (rl.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("resp_arrival", 256'(rl.size() >= n), 256'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"},  256'(req_ready),  256'd0);
    chk({tag, "_resp_valid"}, 256'(resp_valid), 256'd0);
    chk({tag, "_resp_out"},   256'(resp_out),   256'd0);
    chk({tag, "_resp_id"},    256'(resp_id),    256'd0);
    chk({tag, "_resp_err"},   256'(resp_err),   256'd0);
    chk({tag, "_busy"},       256'(busy),       256'd0);
    chk({tag, "_core_en"},    256'(core_en),    256'd0);
    chk({tag, "_core_in"},    256'(core_in),    256'd0);
    chk({tag, "_core_key"},   256'(core_key),   256'd0);
  endtask

  task automatic clear_jobs();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, gb, eb, c;
    int   exp_id  [5];
    fe_t  exp_out [5];

    vec[0] = '{2, fe_t'(5),   fe_t'(7),  fe_t'(12)};
    vec[1] = '{0, fe_t'(100), fe_t'(23), fe_t'(123)};
    vec[2] = '{1, '1,         fe_t'(2),  fe_t'(1)};
    vec[3] = '{3, {53'd0, 1'b1, 200'd0}, fe_t'(5), {53'd0, 1'b1, 200'd5}};

    resp_ready = 1'b0;
    clear_jobs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    resp_ready = 1'b1;

    // Simultaneous requests 1 and 3 straight out of reset.
    push(1, fe_t'(10), fe_t'(1));
    push(3, fe_t'(20), fe_t'(2));
    wait_resp(2, 100);
    chk("sim_id0",  256'(rl[0].id),  256'd1);
    chk("sim_id1",  256'(rl[1].id),  256'd3);
    chk("sim_out0", 256'(rl[0].out), 256'd11);
    chk("sim_out1", 256'(rl[1].out), 256'd22);

    for (int v = 0; v < 4; v++) begin
      base = rl.size();
      gb   = gl.size();
      eb   = el.size();
      push(vec[v].r, vec[v].in, vec[v].key);
      wait_resp(base + 1, 100);
      if (rl.size() > base && gl.size() > gb && el.size() > eb) begin
        chk("vec_gnt_id",  256'(gl[gb].id),    256'(vec[v].r));
        chk("vec_en_cyc",  256'(el[eb]),       256'(gl[gb].cyc + 1));
        chk("vec_rsp_cyc", 256'(rl[base].cyc), 256'(gl[gb].cyc + 2 + LAT));
        chk("vec_out",     256'(rl[base].out), 256'(vec[v].exp_out));
        chk("vec_id",      256'(rl[base].id),  256'(vec[v].r));
        chk("vec_err",     256'(rl[base].err), 256'd0);
      end
    end

    // All four requesters busy; requester 0 queues a second job.
    exp_id  = '{0, 1, 2, 3, 0};
    exp_out = '{fe_t'(3), fe_t'(9), fe_t'(13), fe_t'(17), fe_t'(21)};
    base = rl.size();
    gb   = gl.size();
    push(0, fe_t'(1), fe_t'(2));
    push(1, fe_t'(4), fe_t'(5));
    push(2, fe_t'(6), fe_t'(7));
    push(3, fe_t'(8), fe_t'(9));
    push(0, fe_t'(10), fe_t'(11));
    wait_resp(base + 5, 200);
    for (int k = 0; k < 5; k++) begin
      chk("rr_id",  256'(rl[base + k].id),  256'(exp_id[k]));
      chk("rr_out", 256'(rl[base + k].out), 256'(exp_out[k]));
    end
    for (int k = 0; k < 4; k++)
      chk("rr_period", 256'(gl[gb + k + 1].cyc - gl[gb + k].cyc), 256'(LAT + 3));

    // Response back-pressure with another requester waiting.
    resp_ready = 1'b0;
    base = rl.size();
    gb   = gl.size();
    push(1, fe_t'(30), fe_t'(12));
    push(2, fe_t'(50), fe_t'(1));
    c = 0;
    while (!resp_valid && c < 50) begin
      tick();
      c++;
    end
    chk("bp_resp_valid_rise", 256'(resp_valid), 256'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
      #1;
      chk("bp_valid",     256'(resp_valid), 256'd1);
      chk("bp_out",       256'(resp_out),   256'd42);
      chk("bp_id",        256'(resp_id),    256'd1);
      chk("bp_req_ready", 256'(req_ready),  256'd0);
    end
    chk("bp_no_accept", 256'(rl.size()), 256'(base));
    resp_ready = 1'b1;
    wait_resp(base + 2, 100);
    chk("bp_gnt1_id",  256'(gl[gb + 1].id),    256'd2);
    chk("bp_next_gnt", 256'(gl[gb + 1].cyc),   256'(rl[base].cyc + 1));
    chk("bp_out2",     256'(rl[base + 1].out), 256'd51);

    // Reset while the core is working; the job must vanish.
    base = rl.size();
    eb   = el.size();
    push(3, fe_t'(7), fe_t'(7));
    c = 0;
    while (el.size() == eb && c < 20) begin
      tick();
      c++;
    end
    repeat (3) tick();
    chk("pre_rst_busy", 256'(busy), 256'd1);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    clear_jobs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push(0, fe_t'(1), fe_t'(1));
    wait_resp(base + 1, 100);
    repeat (20) tick();
    chk("post_rst_count", 256'(rl.size()),   256'(base + 1));
    chk("post_rst_out",   256'(rl[base].out), 256'd2);
    chk("post_rst_id",    256'(rl[base].id),  256'd0);

`ifdef MIMC_ARB_TIMEOUT_EN
    no_done = 1'b1;
    base = rl.size();
    gb   = gl.size();
    push(1, fe_t'(9), fe_t'(9));
    wait_resp(base + 1, 100);
    chk("to_err", 256'(rl[base].err), 256'd1);
    chk("to_out", 256'(rl[base].out), 256'd0);
    chk("to_id",  256'(rl[base].id),  256'd1);
    chk("to_cyc", 256'(rl[base].cyc), 256'(gl[gb].cyc + 2 + TO));
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (30) tick();
    chk("stray_no_resp", 256'(rl.size()), 256'(base + 1));
    chk("stray_idle",    256'(busy),      256'd0);
    no_done = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
